// File: rtl/pam_frame_tx.sv
// pam_frame_tx: PAM visible-light TX framer; per request sends preamble (m-sequence x NUM_PREAMBLE), pilot staircase, LENGTH_DATA payload.
// Latency: one registered stage; a state/handshake decision in cycle n appears on da_data/da_valid after edge n+1.
// Backpressure: none toward the DA; mod_tx_ready = (state == DATA); a missing modulator sample becomes mid-scale plus an underrun_err pulse.
// Ports: clk, arst_n (synchronous active-low), tx_en (frame request level), mod_tx_valid/mod_tx_data/mod_tx_ready (modulator handshake),
//        da_data/da_valid (registered DA stream), frame_busy (PRE..GAP), underrun_err (pulse aligned with the mid-scale fill sample).
// Optional: define PAM_TX_UNDERRUN_CNT_EN to add underrun_cnt[15:0], a saturating per-frame underrun count.
module pam_frame_tx #(
  parameter int                         DA_CVER_WIDTH = 12,
  parameter int                         PAM_ORDER     = 4,
  parameter int                         LENGTH_DATA   = 1024,
  parameter int                         LENGTH_M_SEQ  = 15,
  parameter logic [LENGTH_M_SEQ-1:0]    M_SEQ         = 15'b000_0101_0011_0111,
  parameter int                         NUM_PREAMBLE  = 4,
  parameter logic [DA_CVER_WIDTH-1:0]   PRE_HI        = 12'hC00,
  parameter logic [DA_CVER_WIDTH-1:0]   PRE_LO        = 12'h400,
  parameter int                         GAP_LEN       = 32
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     tx_en,
  input  logic                     mod_tx_valid,
  input  logic [DA_CVER_WIDTH-1:0] mod_tx_data,
  output logic                     mod_tx_ready,
  output logic [DA_CVER_WIDTH-1:0] da_data,
  output logic                     da_valid,
  output logic                     frame_busy,
  output logic                     underrun_err
`ifdef PAM_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]              underrun_cnt
`endif
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int PRE_LEN   = NUM_PREAMBLE * LENGTH_M_SEQ;
  localparam int PILOT_LEN = 1 << PAM_ORDER;
  localparam int MAX_LEN   = max2(max2(PRE_LEN, PILOT_LEN), max2(LENGTH_DATA, GAP_LEN));
  localparam int CNT_W     = $clog2(MAX_LEN) + 1;
  localparam logic [DA_CVER_WIDTH-1:0] MID = {1'b1, {(DA_CVER_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PRE, PILOT, DATA, GAP} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [CNT_W-1:0]         chip_off, chip_idx;
  logic                     chip;
  logic [DA_CVER_WIDTH-1:0] pilot_code;
  logic [DA_CVER_WIDTH-1:0] da_data_nxt;
  logic                     da_valid_nxt;
  logic                     underrun_nxt;

  // Gated by reset so no sample is taken while the block is being cleared.
  assign mod_tx_ready = arst_n && (state == DATA);

  // Chip pointer walks the m-sequence MSB first and wraps every LENGTH_M_SEQ samples.
  always_comb begin
    chip_off = cnt % CNT_W'(LENGTH_M_SEQ);
    chip_idx = CNT_W'(LENGTH_M_SEQ - 1) - chip_off;
    chip     = 1'b0;
    for (int i = 0; i < LENGTH_M_SEQ; i++) begin
      if (chip_idx == CNT_W'(i)) chip = M_SEQ[i];
    end
  end

  // Pilot level k sits at the centre of PAM decision region k.
  assign pilot_code = {cnt[PAM_ORDER-1:0], 1'b1, {(DA_CVER_WIDTH-PAM_ORDER-1){1'b0}}};

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + CNT_W'(1);
    da_data_nxt  = MID;
    da_valid_nxt = 1'b0;
    underrun_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (tx_en) state_nxt = PRE;
      end
      PRE: begin
        da_valid_nxt = 1'b1;
        da_data_nxt  = chip ? PRE_HI : PRE_LO;
        if (cnt == CNT_W'(PRE_LEN - 1)) begin
          state_nxt = PILOT;
          cnt_nxt   = '0;
        end
      end
      PILOT: begin
        da_valid_nxt = 1'b1;
        da_data_nxt  = pilot_code;
        if (cnt == CNT_W'(PILOT_LEN - 1)) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
        end
      end
      DATA: begin
        // The frame length is fixed: an empty cycle is filled, never waited out.
        da_valid_nxt = 1'b1;
        if (mod_tx_valid) da_data_nxt  = mod_tx_data;
        else              underrun_nxt = 1'b1;
        if (cnt == CNT_W'(LENGTH_DATA - 1)) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_LEN - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      da_data      <= MID;
      da_valid     <= 1'b0;
      frame_busy   <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      da_data      <= da_data_nxt;
      da_valid     <= da_valid_nxt;
      frame_busy   <= (state != IDLE);
      underrun_err <= underrun_nxt;
    end
  end

`ifdef PAM_TX_UNDERRUN_CNT_EN
  // Cleared when a frame is launched; holds its final value until the next launch.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      underrun_cnt <= '0;
    end else if (state == IDLE && tx_en) begin
      underrun_cnt <= '0;
    end else if (underrun_nxt && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pam_frame_tx.sv
// tb_pam_frame_tx: frame-level bench for pam_frame_tx; full expected frames are queued when a frame is requested
// and compared sample by sample as da_valid samples appear; modulator data is driven only when mod_tx_ready is high.
`timescale 1ns/1ps
module tb_pam_frame_tx;
  localparam int W = 12;

  typedef struct {
    logic [W-1:0] d;
    logic         ur;
  } exp_t;

  typedef struct {
    int           ur_s;
    int           ur_l;
    logic [W-1:0] base;
    int           hold;
    int           exp_ur;
  } vec_t;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         tx_en;
  logic         mod_tx_valid;
  logic [W-1:0] mod_tx_data;
  logic         mod_tx_ready;
  logic [W-1:0] da_data;
  logic         da_valid;
  logic         frame_busy;
  logic         underrun_err;
`ifdef PAM_TX_UNDERRUN_CNT_EN
  logic [15:0]  underrun_cnt;
`endif

  pam_frame_tx dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .tx_en        (tx_en),
    .mod_tx_valid (mod_tx_valid),
    .mod_tx_data  (mod_tx_data),
    .mod_tx_ready (mod_tx_ready),
    .da_data      (da_data),
    .da_valid     (da_valid),
    .frame_busy   (frame_busy),
    .underrun_err (underrun_err)
`ifdef PAM_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t         sbq[$];
  int           checks = 0;
  int           failures = 0;
  int           ur_s = -1;
  int           ur_l = 0;
  logic [W-1:0] base = '0;
  int           dk = 0;
  int           run_len = 0, last_len = 0, ur_run = 0, last_ur = 0;
  int           gap_run = 0, last_gap = 0;
  int           frames_done = 0, valid_rises = 0;
  int           ready_run = 0, last_ready = 0;
  logic         prev_valid = 1'b0, prev_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Expected frame for the current plan (ur_s/ur_l/base).
  task automatic push_frame();
    logic [14:0] pm;
    exp_t        e;
    pm = 15'b000_0101_0011_0111;
    for (int i = 0; i < 60; i++) begin
      e.d  = pm[14 - (i % 15)] ? 12'hC00 : 12'h400;
      e.ur = 1'b0;
      sbq.push_back(e);
    end
    for (int k = 0; k < 16; k++) begin
      e.d  = 12'h080 + 12'(k * 256);
      e.ur = 1'b0;
      sbq.push_back(e);
    end
    for (int j = 0; j < 1024; j++) begin
      if (j >= ur_s && j < ur_s + ur_l) begin
        e.d  = 12'h800;
        e.ur = 1'b1;
      end else begin
        e.d  = base + 12'(j);
        e.ur = 1'b0;
      end
      sbq.push_back(e);
    end
  endtask

  // Samples outputs and drives the modulator side, both on the falling edge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (da_valid) begin
        check("busy_in_frame", 32'(frame_busy), 32'd1);
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra: got sample %03h, required no sample", da_data);
        end else begin
          e = sbq.pop_front();
          check("da_data", 32'(da_data), 32'(e.d));
          check("underrun_err", 32'(underrun_err), 32'(e.ur));
        end
        if (!prev_valid) begin
          if (valid_rises > 0) last_gap = gap_run;
          valid_rises++;
          run_len = 0;
          ur_run  = 0;
        end
        run_len++;
        if (underrun_err) ur_run++;
      end else begin
        check("err_outside_frame", 32'(underrun_err), 32'd0);
        if (prev_valid) begin
          last_len = run_len;
          last_ur  = ur_run;
          frames_done++;
          gap_run = 0;
        end
        gap_run++;
      end
      prev_valid = da_valid;
      if (mod_tx_ready) ready_run++;
      else if (prev_ready) begin
        last_ready = ready_run;
        ready_run  = 0;
      end
      prev_ready = mod_tx_ready;
      if (mod_tx_ready) begin
        mod_tx_valid = !(dk >= ur_s && dk < ur_s + ur_l);
        mod_tx_data  = base + 12'(dk);
        dk++;
      end else begin
        dk           = 0;
        mod_tx_valid = 1'b1;
        mod_tx_data  = 12'hABC;
      end
    end
  endtask

  task automatic start_frame(input int hold);
    @(negedge clk);
    tx_en = 1'b1;
    @(negedge clk);
    if (hold <= 1) tx_en = 1'b0;
    check("pre_latency_valid", 32'(da_valid), 32'd0);
    @(negedge clk);
    check("first_chip_valid", 32'(da_valid), 32'd1);
    check("first_chip_data", 32'(da_data), 32'h400);
    check("ready_in_pre", 32'(mod_tx_ready), 32'd0);
    for (int i = 2; i < hold; i++) @(negedge clk);
    tx_en = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("frame_end_timeout", 32'(frames_done), 32'(target));
  endtask

  task automatic frame_checks(input int exp_ur);
    int r;
    check("frame_len", 32'(last_len), 32'd1100);
    check("ready_run", 32'(last_ready), 32'd1024);
    check("ur_pulses", 32'(last_ur), 32'(exp_ur));
    check("sb_drained", 32'(sbq.size()), 32'd0);
    @(negedge clk);
    check("ready_in_gap", 32'(mod_tx_ready), 32'd0);
    check("busy_in_gap", 32'(frame_busy), 32'd1);
`ifdef PAM_TX_UNDERRUN_CNT_EN
    check("underrun_cnt", 32'(underrun_cnt), 32'(exp_ur));
`endif
    r = valid_rises;
    repeat (60) @(negedge clk);
    check("idle_busy", 32'(frame_busy), 32'd0);
    check("idle_data", 32'(da_data), 32'h800);
    check("idle_ready", 32'(mod_tx_ready), 32'd0);
    check("no_restart", 32'(valid_rises), 32'(r));
`ifdef PAM_TX_UNDERRUN_CNT_EN
    check("underrun_cnt_hold", 32'(underrun_cnt), 32'(exp_ur));
`endif
  endtask

  initial begin
    vec_t vt[4];
    int   f, r, n;
    vt[0] = '{-1,   0, 12'h000,  1, 0};
    vt[1] = '{100,  3, 12'h123,  1, 3};
    vt[2] = '{0,    1, 12'hFF0, 30, 1};
    vt[3] = '{1023, 1, 12'h555,  1, 1};

    arst_n       = 1'b0;
    tx_en        = 1'b0;
    mod_tx_valid = 1'b1;
    mod_tx_data  = '0;
    #1;
    check("rst_ready_low", 32'(mod_tx_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_valid", 32'(da_valid), 32'd0);
    check("rst_data", 32'(da_data), 32'h800);
    check("rst_busy", 32'(frame_busy), 32'd0);
    check("rst_err", 32'(underrun_err), 32'd0);
`ifdef PAM_TX_UNDERRUN_CNT_EN
    check("rst_ucnt", 32'(underrun_cnt), 32'd0);
`endif
    @(negedge clk);
    arst_n = 1'b1;
    fork
      monitor();
    join_none
    repeat (10) @(negedge clk);
    check("idle_ready_valid_held", 32'(mod_tx_ready), 32'd0);
    check("idle_no_frame", 32'(da_valid), 32'd0);

    for (int i = 0; i < 4; i++) begin
      ur_s = vt[i].ur_s;
      ur_l = vt[i].ur_l;
      base = vt[i].base;
      push_frame();
      f = frames_done;
      start_frame(vt[i].hold);
      wait_frames(f + 1);
      frame_checks(vt[i].exp_ur);
    end

    // tx_en held high: two frames back to back with the minimum spacing.
    ur_s = -1; ur_l = 0; base = 12'h700;
    push_frame();
    push_frame();
    f = frames_done;
    r = valid_rises;
    @(negedge clk);
    tx_en = 1'b1;
    n = 0;
    while (valid_rises < r + 2 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    tx_en = 1'b0;
    check("b2b_second_start", 32'(valid_rises), 32'(r + 2));
    wait_frames(f + 2);
    check("b2b_gap", 32'(last_gap), 32'd33);
    frame_checks(0);

    // Reset during DATA sample 500: frame abandoned, nothing resumes.
    ur_s = 200; ur_l = 2; base = 12'h200;
    push_frame();
    r = valid_rises;
    start_frame(1);
    n = 0;
    while (dk != 500 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_data500", 32'(dk), 32'd500);
    arst_n = 1'b0;
    #1;
    check("ready_during_rst", 32'(mod_tx_ready), 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    check("midrst_valid", 32'(da_valid), 32'd0);
    check("midrst_data", 32'(da_data), 32'h800);
    check("midrst_ready", 32'(mod_tx_ready), 32'd0);
    check("midrst_busy", 32'(frame_busy), 32'd0);
    check("midrst_err", 32'(underrun_err), 32'd0);
`ifdef PAM_TX_UNDERRUN_CNT_EN
    check("midrst_ucnt", 32'(underrun_cnt), 32'd0);
`endif
    check("midrst_unsent", 32'(sbq.size()), 32'd524);
    sbq.delete();
    repeat (100) @(negedge clk);
    check("midrst_len", 32'(last_len), 32'd576);
    check("midrst_ready_run", 32'(last_ready), 32'd500);
    check("midrst_ur_pulses", 32'(last_ur), 32'd2);
    check("midrst_no_resume", 32'(valid_rises), 32'(r + 1));

    // Recovery: a clean frame after the abandoned one.
    ur_s = 512; ur_l = 4; base = 12'h321;
    push_frame();
    f = frames_done;
    start_frame(1);
    wait_frames(f + 1);
    frame_checks(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pam_frame_tx.md
# pam_frame_tx

Transmit-side framer for the PAM visible-light link. It sits between the PAM modulator and the DA converter and emits one complete frame per request:
- a preamble of four back-to-back m-sequences, which the receiver synchronizer correlates against;
- a pilot of `1<<PAM_ORDER` known samples;
- `LENGTH_DATA` modulated samples pulled from the modulator over a valid/ready handshake.

The DA stream is continuous while a frame is in flight, so the receiver's fixed `LENGTH_DATA + (1<<PAM_ORDER)` sample count always lines up.

## Interface
Parameters:
- `DA_CVER_WIDTH`, 12, DA sample width (offset-binary; mid-scale = `1 << (DA_CVER_WIDTH-1)`)
- `PAM_ORDER`, 4, pilot length is `1<<PAM_ORDER`
- `LENGTH_DATA`, 1024, payload samples per frame
- `LENGTH_M_SEQ`, 15, m-sequence chips
- `M_SEQ`, 15'b000_0101_0011_0111, chip pattern, sent MSB (bit 14) first
- `NUM_PREAMBLE`, 4, m-sequence repetitions
- `PRE_HI`, 12'hC00, DA code for chip 1 (MSB set)
- `PRE_LO`, 12'h400, DA code for chip 0 (MSB clear)
- `GAP_LEN`, 32, minimum idle cycles between frames

Ports:
- `clk` in 1, single clock; all logic on the rising edge
- `arst_n` in 1, synchronous active-low reset (the name is kept; the reset is sampled on `clk`)
- `tx_en` in 1, frame request level
- `mod_tx_valid` in 1, modulator sample valid
- `mod_tx_data` in `DA_CVER_WIDTH`, modulator sample
- `mod_tx_ready` out 1, framer accepts sample
- `da_data` out `DA_CVER_WIDTH`, registered DA code
- `da_valid` out 1, high for every frame sample
- `frame_busy` out 1, high from the PRE state through the GAP state
- `underrun_err` out 1, one-cycle pulse per underrun sample

## Operation
States: `IDLE`, `PRE`, `PILOT`, `DATA`, `GAP`. A single sample counter `cnt` is cleared on every state entry.

- `IDLE`
  - Outputs: `da_data` = mid-scale, `da_valid` = 0.
  - Transition: `tx_en` = 1 → `PRE`.
- `PRE`
  - Runs for `NUM_PREAMBLE*LENGTH_M_SEQ` = 60 cycles.
  - Chip index = `LENGTH_M_SEQ-1 - (cnt mod LENGTH_M_SEQ)`; the chip index wraps every 15 cycles.
  - `da_data` = `PRE_HI` or `PRE_LO` according to the chip value.
  - Last count → `PILOT`.
- `PILOT`
  - Runs for `1<<PAM_ORDER` cycles.
  - Sample k = `{k[PAM_ORDER-1:0], 1'b1, zeros}` (the code is widened to `DA_CVER_WIDTH`). This gives an ascending staircase of level centres, e.g. 12'h080, 12'h180, … 12'hF80.
  - Last count → `DATA`.
- `DATA`
  - Runs for exactly `LENGTH_DATA` cycles.
  - `mod_tx_ready` = 1 for the whole state.
  - When `mod_tx_valid` = 1 in a cycle, `mod_tx_data` is forwarded.
  - When `mod_tx_valid` = 0 in a cycle (underrun): mid-scale is sent, `underrun_err` pulses, and `cnt` still advances. The frame is never stretched.
  - Last count → `GAP`.
- `GAP`
  - Runs for `GAP_LEN` cycles with `da_valid` = 0 and mid-scale output.
  - Then → `IDLE`.

Further rules:
- `mod_tx_ready` is combinational: `state == DATA`. It is 0 in every other state.
- `tx_en` is sampled only in `IDLE`. Dropping it mid-frame does not abort the frame.
- Counter width is `$clog2` of the largest state length, +1.

## Timing
- Reset values (one edge with `arst_n` = 0): state `IDLE`, `cnt` 0, `da_data` = mid-scale (12'h800), `da_valid` 0, `frame_busy` 0, `underrun_err` 0.
  - `mod_tx_ready` reads 0 in the same cycle `arst_n` is low.
- Reset mid-frame: the frame is abandoned at that edge; no further preamble, pilot or data samples are sent.
- Latency: a state or handshake decision in cycle n appears on `da_data`/`da_valid` at edge n+1.
  - Data accepted on `mod_tx_valid && mod_tx_ready` in cycle n is on `da_data` after edge n+1.
  - `underrun_err` is registered and aligned with the mid-scale sample it flags.
- Frame length: exactly 60 + 16 + 1024 = 1100 consecutive `da_valid` cycles.
- Frame spacing: at least `GAP_LEN`+1 cycles from the last frame sample to the next first preamble chip.
  - The +1 is the `IDLE` decision cycle.
- `tx_en` held high: frames repeat back-to-back with exactly that spacing.
- `frame_busy` is registered alongside `da_valid` and stays high through `GAP`.

## Configuration
- `PAM_TX_UNDERRUN_CNT_EN` defined:
  - Adds output port `underrun_cnt` [15:0].
  - Counts underrun samples in the current frame, saturating at 16'hFFFF.
  - Cleared on entry to `PRE` and on reset.
  - Holds its value through `GAP` and `IDLE`.
- Not defined: the port and counter are absent; only `underrun_err` pulses are reported.

## Test plan
- Reset then `tx_en` = 1 with `mod_tx_valid` held at 1 and data = a 12-bit incrementing counter:
  - First 60 `da_valid` samples: MSBs = 000010100110111 repeated 4×.
  - Next 16 samples: 12'h080 … 12'hF80.
  - Next 1024 samples equal the input stream.
  - `da_valid` then falls, and `mod_tx_ready` was high for exactly 1024 cycles.
- Drop `mod_tx_valid` for data samples 100–102:
  - Those three outputs are 12'h800 with `underrun_err` pulsing.
  - Total frame length is still 1100; `underrun_cnt` = 3 when the macro is enabled.
- Hold `tx_en` = 1 continuously: the gap between frames is exactly `GAP_LEN`+1 cycles of `da_valid` = 0.
- Pulse `tx_en` for one cycle in `IDLE`, then deassert mid-preamble: the full 1100-sample frame is still sent, then the block stays in `IDLE`.
- Assert `arst_n` = 0 for one cycle during `DATA` sample 500: next edge shows `da_valid` 0, `da_data` 12'h800, `mod_tx_ready` 0, and no frame resumes until `tx_en`.
- Hold `mod_tx_valid` = 1 outside `DATA`: no sample is consumed (`mod_tx_ready` = 0) in `PRE`, `PILOT`, `GAP` or `IDLE`.
